// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse stream to clamped absolute cursor, buttons and event count (2-stage CAPTURE/APPLY).
// Optional wheel accumulator enabled by defining MOUSE_WHEEL_EN.
module ps2_mouse_tracker #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239,
    parameter int SHIFT = 0
) (
    input  logic        i_clk_sys,
    input  logic        i_reset_n,
    input  logic [24:0] i_ps2_mouse,
    input  logic [15:0] i_ps2_mouse_ext,
    input  logic        i_home,
    output logic [9:0]  o_pos_x,
    output logic [8:0]  o_pos_y,
    output logic [2:0]  o_btn,
    output logic        o_evt_strobe,
    output logic [7:0]  o_evt_count,
    output logic [7:0]  o_wheel_pos
);

    localparam logic [9:0]         X_CTR = 10'(X_MAX / 2);
    localparam logic [8:0]         Y_CTR = 9'(Y_MAX / 2);
    localparam logic [9:0]         X_HI  = 10'(X_MAX);
    localparam logic [8:0]         Y_HI  = 9'(Y_MAX);
    localparam logic signed [11:0] X_HS  = 12'(X_MAX);
    localparam logic signed [11:0] Y_HS  = 12'(Y_MAX);

    logic                r_tog;
    logic                r_armed;
    logic                w_evt;
    logic signed [8:0]   w_dx_raw;
    logic signed [8:0]   w_dy_raw;
    logic signed [8:0]   w_dx;
    logic signed [8:0]   w_dy;
    logic                r_cap_vld;
    logic signed [8:0]   r_dx;
    logic signed [8:0]   r_dy;
    logic [2:0]          r_cap_btn;
    logic signed [11:0]  w_nx;
    logic signed [11:0]  w_ny;
    logic [9:0]          w_cx;
    logic [8:0]          w_cy;

    // The toggle copy follows the input every cycle; the first cycle only arms.
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tog   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_tog   <= i_ps2_mouse[24];
            r_armed <= 1'b1;
        end
    end

    assign w_evt    = r_armed && (i_ps2_mouse[24] != r_tog);
    assign w_dx_raw = i_ps2_mouse[6] ? 9'sd0 : $signed({i_ps2_mouse[4], i_ps2_mouse[15:8]});
    assign w_dy_raw = i_ps2_mouse[7] ? 9'sd0 : $signed({i_ps2_mouse[5], i_ps2_mouse[23:16]});
    assign w_dx     = w_dx_raw >>> SHIFT;
    assign w_dy     = w_dy_raw >>> SHIFT;

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cap_vld <= 1'b0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_cap_btn <= '0;
        end else begin
            r_cap_vld <= w_evt;
            if (w_evt) begin
                r_dx      <= w_dx;
                r_dy      <= w_dy;
                r_cap_btn <= i_ps2_mouse[2:0];
            end
        end
    end

    // PS/2 +Y is up while screen Y grows downward, hence the subtraction.
    assign w_nx = $signed({2'b00, o_pos_x}) + $signed({{3{r_dx[8]}}, r_dx});
    assign w_ny = $signed({3'b000, o_pos_y}) - $signed({{3{r_dy[8]}}, r_dy});

    always_comb begin
        w_cx = w_nx[9:0];
        w_cy = w_ny[8:0];
        if (w_nx < 12'sd0)
            w_cx = '0;
        else if (w_nx > X_HS)
            w_cx = X_HI;
        if (w_ny < 12'sd0)
            w_cy = '0;
        else if (w_ny > Y_HS)
            w_cy = Y_HI;
    end

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pos_x      <= X_CTR;
            o_pos_y      <= Y_CTR;
            o_btn        <= '0;
            o_evt_strobe <= 1'b0;
            o_evt_count  <= '0;
        end else begin
            o_evt_strobe <= r_cap_vld;
            if (i_home) begin
                o_pos_x <= X_CTR;
                o_pos_y <= Y_CTR;
            end else if (r_cap_vld) begin
                o_pos_x <= w_cx;
                o_pos_y <= w_cy;
            end
            if (r_cap_vld) begin
                o_btn       <= r_cap_btn;
                o_evt_count <= o_evt_count + 8'd1;
            end
        end
    end

`ifdef MOUSE_WHEEL_EN
    logic [7:0]        r_cap_whl;
    logic signed [8:0] w_wsum;
    logic              w_unused_bits;

    assign w_unused_bits = ^{i_ps2_mouse[3], i_ps2_mouse_ext[15:8]};
    assign w_wsum = $signed({o_wheel_pos[7], o_wheel_pos}) + $signed({r_cap_whl[7], r_cap_whl});

    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cap_whl   <= '0;
            o_wheel_pos <= '0;
        end else begin
            if (w_evt)
                r_cap_whl <= i_ps2_mouse_ext[7:0];
            // Saturate instead of wrapping when the 9-bit sum leaves the 8-bit range.
            if (r_cap_vld) begin
                if (w_wsum[8] != w_wsum[7])
                    o_wheel_pos <= w_wsum[8] ? 8'h80 : 8'h7F;
                else
                    o_wheel_pos <= w_wsum[7:0];
            end
        end
    end
`else
    logic w_unused_bits;

    assign w_unused_bits = ^{i_ps2_mouse[3], i_ps2_mouse_ext};
    assign o_wheel_pos   = '0;
`endif

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed + random bench for ps2_mouse_tracker with an arithmetic reference model.
module tb_ps2_mouse_tracker;
    localparam int XM = 319;
    localparam int YM = 239;
    localparam int SH = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:0] ms = '0;
    logic [15:0] ext = '0;
    logic        home = 1'b0;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic [2:0]  btn;
    logic        strobe;
    logic [7:0]  cnt;
    logic [7:0]  wheel;

    int errors = 0;
    int checks = 0;
    int mx = 159, my = 119, mcnt = 0, mwh = 0;
    logic [2:0] mbtn = '0;
    logic       mtog = 1'b0;

    int ex_x[$], ex_y[$], ex_c[$], ex_w[$];
    logic [2:0] ex_b[$];

    ps2_mouse_tracker #(.X_MAX(XM), .Y_MAX(YM), .SHIFT(SH)) dut (
        .i_clk_sys(clk), .i_reset_n(rst_n), .i_ps2_mouse(ms), .i_ps2_mouse_ext(ext),
        .i_home(home), .o_pos_x(pos_x), .o_pos_y(pos_y), .o_btn(btn),
        .o_evt_strobe(strobe), .o_evt_count(cnt), .o_wheel_pos(wheel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic m_reset();
        mx = XM / 2; my = YM / 2; mcnt = 0; mwh = 0; mbtn = '0;
    endtask

    // Reference: 9-bit sign/magnitude-free deltas as plain integers, clamp by arithmetic.
    task automatic m_apply(input logic [7:0] dX, input logic [7:0] dY, input logic xs,
                           input logic ys, input logic xo, input logic yo,
                           input logic [2:0] b, input logic [7:0] wh);
        int dx, dy, w;
        dx = xo ? 0 : (xs ? int'(dX) - 256 : int'(dX));
        dy = yo ? 0 : (ys ? int'(dY) - 256 : int'(dY));
        dx = dx >>> SH;
        dy = dy >>> SH;
        mx = clampi(mx + dx, XM);
        my = clampi(my - dy, YM);
        mbtn = b;
        mcnt = (mcnt + 1) % 256;
        w = mwh + (wh[7] ? int'(wh) - 256 : int'(wh));
`ifdef MOUSE_WHEEL_EN
        mwh = (w > 127) ? 127 : ((w < -128) ? -128 : w);
`else
        mwh = (w > 1000) ? 0 : 0;
`endif
    endtask

    task automatic drive(input logic [7:0] dX, input logic [7:0] dY, input logic xs,
                         input logic ys, input logic xo, input logic yo,
                         input logic [2:0] b, input logic [7:0] wh);
        ms   = {~mtog, dY, dX, yo, xo, ys, xs, 1'b0, b};
        ext  = {8'h00, wh};
        mtog = ~mtog;
        m_apply(dX, dY, xs, ys, xo, yo, b, wh);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_x"}, 32'(pos_x), 32'(mx));
        chk({tag, "_y"}, 32'(pos_y), 32'(my));
        chk({tag, "_btn"}, 32'(btn), 32'(mbtn));
        chk({tag, "_cnt"}, 32'(cnt), 32'(mcnt));
        chk({tag, "_wheel"}, 32'(wheel), 32'(8'(mwh)));
    endtask

    // One isolated event: quiet cycle after capture, strobe + new state after apply.
    task automatic ev(input string tag, input logic [7:0] dX, input logic [7:0] dY,
                      input logic xs, input logic ys, input logic xo, input logic yo,
                      input logic [2:0] b, input logic [7:0] wh);
        @(negedge clk);
        drive(dX, dY, xs, ys, xo, yo, b, wh);
        @(negedge clk);
        chk({tag, "_pre_stb"}, 32'(strobe), 32'd0);
        @(negedge clk);
        chk({tag, "_stb"}, 32'(strobe), 32'd1);
        chk_state(tag);
    endtask

    initial begin
        // 1: reset released with toggle high must not produce an event.
        ms[24] = 1'b1; mtog = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(pos_x), 32'd159);
        chk("rst_y", 32'(pos_y), 32'd119);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("arm_stb", 32'(strobe), 32'd0);
        end
        chk_state("arm");

        // 2: basic move.
        ev("t2", 8'd5, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
        chk("t2_x_const", 32'(pos_x), 32'd164);
        chk("t2_y_const", 32'(pos_y), 32'd116);
        @(negedge clk);
        chk("t2_stb_1cyc", 32'(strobe), 32'd0);

        // 3: clamp low then high.
        ev("t3a", 8'h38, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
        chk("t3a_x0", 32'(pos_x), 32'd0);
        repeat (3) ev("t3b", 8'd127, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
        chk("t3b_x319", 32'(pos_x), 32'd319);

        // 4: X overflow zeroes only that axis.
        ev("t4", 8'd20, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 8'd0);

        // 5: home coinciding with APPLY.
        @(negedge clk);
        drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 8'd0);
        @(negedge clk);
        home = 1'b1;
        chk("t5_pre_stb", 32'(strobe), 32'd0);
        @(negedge clk);
        home = 1'b0;
        mx = XM / 2; my = YM / 2;
        chk("t5_stb", 32'(strobe), 32'd1);
        chk_state("t5");

        // Capture in flight while home is taken: applied relative to centre.
        ev("mv", 8'd40, 8'd30, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 8'd0);
        @(negedge clk);
        home = 1'b1;
        mx = XM / 2; my = YM / 2;
        drive(8'd10, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 8'd0);
        @(negedge clk);
        home = 1'b0;
        @(negedge clk);
        chk("hcap_stb", 32'(strobe), 32'd1);
        chk_state("hcap");

        // home alone.
        ev("mv2", 8'd7, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 8'd0);
        @(negedge clk);
        home = 1'b1;
        @(negedge clk);
        home = 1'b0;
        mx = XM / 2; my = YM / 2;
        chk("home_stb", 32'(strobe), 32'd0);
        chk_state("home");

        // Reset with an event in CAPTURE: discarded, re-arm, no strobe.
        @(negedge clk);
        drive(8'd50, 8'd50, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        m_reset();
        #1 chk_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rearm_stb", 32'(strobe), 32'd0);
        end
        chk_state("rearm");

        // 6: wheel saturation (stays 0 without the wheel build).
        repeat (3) ev("t6", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'd100);
        repeat (3) ev("t6n", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h9C);

        // Random spaced events.
        for (int i = 0; i < 20; i++) begin
            ev("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
               3'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Random back-to-back burst: a new toggle every cycle, none may be dropped.
        for (int j = 0; j < 44; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                chk("bb_stb", 32'(strobe), 32'd1);
                chk("bb_x", 32'(pos_x), 32'(ex_x.pop_front()));
                chk("bb_y", 32'(pos_y), 32'(ex_y.pop_front()));
                chk("bb_btn", 32'(btn), 32'(ex_b.pop_front()));
                chk("bb_cnt", 32'(cnt), 32'(ex_c.pop_front()));
                chk("bb_wheel", 32'(wheel), 32'(8'(ex_w.pop_front())));
            end else begin
                chk("bb_pre_stb", 32'(strobe), 32'd0);
            end
            if (j < 42) begin
                drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                      3'($urandom), 8'($urandom));
                ex_x.push_back(mx); ex_y.push_back(my); ex_b.push_back(mbtn);
                ex_c.push_back(mcnt); ex_w.push_back(mwh);
            end
        end
        @(negedge clk);
        chk("bb_end_stb", 32'(strobe), 32'd0);
        chk_state("bb_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
